midi_poly_voice_engine: RTL
===========================

MIDI_POLY_VOICE_ENGINE -- requirements
Module: midi_poly_voice_engine

Interface
REQ-001 SHALL have parameter D_W, default 16, sample width and note-increment width.
REQ-002 SHALL have parameter ADDR_W, default 8, sine-table address width.
REQ-003 SHALL have parameter PHASE_W, default 24, phase accumulator width, >= ADDR_W.
REQ-004 SHALL have parameter NUM_VOICES, default 4, power of two, 2..16; VC_W = clog2(NUM_VOICES).
REQ-005 SHALL have parameter OMNI, default 1; when 0, only MIDI channel MIDI_CH is accepted.
REQ-006 SHALL have parameter MIDI_CH, default 0, 4-bit channel number.
REQ-007 sys_clk  in  1  single clock, all logic on rising edge.
REQ-008 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 pkt_valid  in  1  MIDI packet presented.
REQ-010 pkt_ready  out  1  engine can accept a packet.
REQ-011 MIDI_CMD  in  8  status byte.
REQ-012 MIDI_DAT_0  in  8  note number.
REQ-013 MIDI_DAT_1  in  8  velocity.
REQ-014 note_lut_addr  out  8  note-to-increment table address.
REQ-015 note_lut_data  in  D_W  increment, valid one cycle after address.
REQ-016 sin_addr  out  ADDR_W  sine-table address.
REQ-017 sin_data  in  D_W  sample, valid one cycle after address.
REQ-018 TDM_VOICE_DATA  out  D_W  current slot sample.
REQ-019 TDM_CHANNEL  out  VC_W  current slot voice index.
REQ-020 TDM_CHAN_ENABLED  out  1  current slot voice active.
REQ-021 TDM_VALID  out  1  one-cycle strobe, TDM outputs updated.
REQ-022 voices_active  out  NUM_VOICES  per-voice active bitmap.

Function
REQ-023 A packet SHALL transfer on a cycle where pkt_valid and pkt_ready are both 1; pkt_ready SHALL be 1 only in state IDLE.
REQ-024 Decode: note-on = CMD[7:4]==9 with DAT_1!=0; note-off = CMD[7:4]==8, or 9 with DAT_1==0; all other commands and filtered channels SHALL be consumed with no effect.
REQ-025 Control FSM states: IDLE, LOOKUP, ALLOC, WRITE; IDLE->LOOKUP on accepted note-on, driving note_lut_addr=DAT_0 in LOOKUP; LOOKUP->ALLOC; ALLOC->WRITE; WRITE->IDLE; note-off SHALL be applied in the acceptance cycle and the FSM SHALL stay in IDLE.
REQ-026 Allocation priority in ALLOC: (a) active voice already holding the same note (retrigger), else (b) lowest-index inactive voice, else (c) voice at steal pointer.
REQ-027 Steal pointer SHALL increment modulo NUM_VOICES on every steal only.
REQ-028 WRITE SHALL store note, increment = note_lut_data, set active, and clear the voice phase to 0.
REQ-029 Note-off SHALL clear active on every voice whose note matches; no match SHALL have no effect.
REQ-030 Output sequencer, independent of FSM: slot counter cycles 0..NUM_VOICES-1, 2 cycles per slot (ISSUE, CAPTURE), wrapping to 0.
REQ-031 ISSUE SHALL drive sin_addr = phase[slot][PHASE_W-1 -: ADDR_W]; CAPTURE SHALL register TDM_VOICE_DATA = sin_data if the voice is active, else 0, set TDM_CHANNEL=slot and TDM_CHAN_ENABLED=active, and pulse TDM_VALID.
REQ-032 In CAPTURE, active voices SHALL add increment to phase modulo 2^PHASE_W (wrap silently); inactive phases SHALL hold.
REQ-033 WRITE coinciding with CAPTURE of the same voice: WRITE SHALL win (phase 0, no add).
REQ-034 Note-off coinciding with CAPTURE of the same voice: the captured sample SHALL use pre-clear state; the voice SHALL be inactive from the next cycle.
REQ-035 voices_active SHALL reflect the active flags with zero latency from the register.

Reset
REQ-036 On sys_rst_n low: FSM=IDLE, pkt_ready=0 until release, slot=0, steal pointer=0, all active=0, phases=0, increments=0, notes=0, note_lut_addr=0, sin_addr=0, TDM outputs=0, TDM_VALID=0.
REQ-037 Reset mid-allocation SHALL abandon the note-on with no voice modified after release.

Structure
REQ-038 Shared package SHALL hold FSM state encoding, MIDI status nibble constants (NOTE_ON=9, NOTE_OFF=8) and VC_W derivation.
REQ-039 Voice allocation search (match/free/steal, priority encoded) SHALL be one sub-module, voice_alloc_picker; tables stay external.

Verification
REQ-040 Reset, then note-on 0x90/60/100 with note_lut_data=0x0100 -> voice 0 active after 3 cycles, voices_active=0001, phase advances 0x0100 per frame.
REQ-041 Five note-ons notes 60..64, NUM_VOICES=4 -> voices 0..3 hold 60..63; fifth steals voice 0 (note 64), steal pointer=1.
REQ-042 Note-on 60 then 0x90/60/0 -> voice cleared, its next TDM slot shows TDM_CHAN_ENABLED=0, data 0x0000.
REQ-043 Repeated note-on 60 -> same voice retriggered, phase 0, no second voice used.
REQ-044 OMNI=0, MIDI_CH=0, note-on on channel 3 -> consumed, voices_active unchanged.
REQ-045 Increment 0xFFFF, PHASE_W=16 -> phase wraps modulo 2^16; sys_rst_n pulsed during LOOKUP -> all voices inactive afterwards.

Source files
------------

// File: rtl/midi_poly_voice_engine_pkg.sv
// -----------------------------------------------------------------------------
// midi_poly_voice_engine_pkg
// Shared definitions for the polyphonic MIDI voice engine:
//   - control FSM state encoding
//   - MIDI status nibble constants
//   - voice-index width derivation
// -----------------------------------------------------------------------------
package midi_poly_voice_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_ALLOC  = 2'd2,
      ST_WRITE  = 2'd3
   } fsm_state_t;

   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] NOTE_OFF = 4'h8;

   // Voice-index width; a two-voice engine still needs one index bit.
   function automatic int vc_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/midi_poly_voice_engine_voice_alloc_picker.sv
// -----------------------------------------------------------------------------
// voice_alloc_picker
// Combinational voice-allocation search. Priority:
//   1. lowest-index active voice already holding the requested note (retrigger)
//   2. lowest-index inactive voice
//   3. the voice at the steal pointer
// Ports:
//   active    in  per-voice active flags
//   notes     in  per-voice stored note numbers
//   note      in  note being allocated
//   steal_ptr in  round-robin steal candidate
//   pick      out chosen voice index
//   steal     out 1 when the choice came from the steal pointer
// -----------------------------------------------------------------------------
module voice_alloc_picker #(
   parameter int NUM_VOICES = 4,
   parameter int VC_W       = 2
) (
   input  logic [NUM_VOICES-1:0]      active,
   input  logic [NUM_VOICES-1:0][7:0] notes,
   input  logic [7:0]                 note,
   input  logic [VC_W-1:0]            steal_ptr,
   output logic [VC_W-1:0]            pick,
   output logic                       steal
);

   logic            hit;
   logic            free;
   logic [VC_W-1:0] hit_idx;
   logic [VC_W-1:0] free_idx;

   // Scanning from the top down lets the lowest matching index win.
   always_comb begin
      hit      = 1'b0;
      free     = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (active[v] && (notes[v] == note)) begin
            hit     = 1'b1;
            hit_idx = VC_W'(v);
         end
         if (!active[v]) begin
            free     = 1'b1;
            free_idx = VC_W'(v);
         end
      end
   end

   always_comb begin
      pick  = steal_ptr;
      steal = 1'b0;
      if (hit) begin
         pick = hit_idx;
      end else if (free) begin
         pick = free_idx;
      end else begin
         steal = 1'b1;
      end
   end

endmodule

// File: rtl/midi_poly_voice_engine.sv
// -----------------------------------------------------------------------------
// midi_poly_voice_engine
// Polyphonic wavetable voice engine driven by MIDI note-on/note-off packets.
// A control FSM looks up the note increment and allocates a voice; an
// independent TDM sequencer visits each voice for two cycles (ISSUE the
// sine-table address, CAPTURE the returned sample) and advances its phase.
// Ports:
//   sys_clk, sys_rst_n       clock, asynchronous active-low reset
//   pkt_valid / pkt_ready    MIDI packet handshake
//   MIDI_CMD, MIDI_DAT_0/1   status byte, note number, velocity
//   note_lut_addr/_data      external note-to-increment table (1-cycle latency)
//   sin_addr / sin_data      external sine table (1-cycle latency)
//   TDM_VOICE_DATA           sample of the slot just captured
//   TDM_CHANNEL              voice index of that slot
//   TDM_CHAN_ENABLED         voice was active when captured
//   TDM_VALID                one-cycle strobe when TDM outputs update
//   voices_active            per-voice active bitmap
// -----------------------------------------------------------------------------
module midi_poly_voice_engine
   import midi_poly_voice_engine_pkg::*;
#(
   parameter int         D_W        = 16,
   parameter int         ADDR_W     = 8,
   parameter int         PHASE_W    = 24,
   parameter int         NUM_VOICES = 4,
   parameter int         OMNI       = 1,
   parameter logic [3:0] MIDI_CH    = 4'd0,
   localparam int        VC_W       = vc_width(NUM_VOICES)
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  pkt_valid,
   output logic                  pkt_ready,
   input  logic [7:0]            MIDI_CMD,
   input  logic [7:0]            MIDI_DAT_0,
   input  logic [7:0]            MIDI_DAT_1,
   output logic [7:0]            note_lut_addr,
   input  logic [D_W-1:0]        note_lut_data,
   output logic [ADDR_W-1:0]     sin_addr,
   input  logic [D_W-1:0]        sin_data,
   output logic [D_W-1:0]        TDM_VOICE_DATA,
   output logic [VC_W-1:0]       TDM_CHANNEL,
   output logic                  TDM_CHAN_ENABLED,
   output logic                  TDM_VALID,
   output logic [NUM_VOICES-1:0] voices_active
);

   fsm_state_t                  state;
   logic [VC_W-1:0]             alloc_idx;
   logic [D_W-1:0]              alloc_inc;
   logic [VC_W-1:0]             steal_ptr;

   logic [NUM_VOICES-1:0]       active;
   logic [NUM_VOICES-1:0][7:0]  notes;
   logic [D_W-1:0]              incs   [NUM_VOICES];
   logic [PHASE_W-1:0]          phases [NUM_VOICES];

   logic [VC_W-1:0]             slot;
   logic                        seq_cap;

   logic                        accept;
   logic                        ch_ok;
   logic                        is_on;
   logic                        is_off;
   logic                        write_en;
   logic [VC_W-1:0]             pick;
   logic                        pick_steal;

   // Packet decode; filtered channels and other commands are accepted
   // and simply produce neither strobe.
   always_comb begin
      accept   = pkt_valid && pkt_ready;
      ch_ok    = (OMNI != 0) || (MIDI_CMD[3:0] == MIDI_CH);
      is_on    = accept && ch_ok && (MIDI_CMD[7:4] == NOTE_ON) && (MIDI_DAT_1 != 8'd0);
      is_off   = accept && ch_ok &&
                 ((MIDI_CMD[7:4] == NOTE_OFF) ||
                  ((MIDI_CMD[7:4] == NOTE_ON) && (MIDI_DAT_1 == 8'd0)));
      write_en = (state == ST_WRITE);
   end

   // note_lut_addr is held from acceptance to WRITE, so it doubles as the
   // latched note number for the allocation search and the voice write.
   voice_alloc_picker #(
      .NUM_VOICES (NUM_VOICES),
      .VC_W       (VC_W)
   ) u_picker (
      .active    (active),
      .notes     (notes),
      .note      (note_lut_addr),
      .steal_ptr (steal_ptr),
      .pick      (pick),
      .steal     (pick_steal)
   );

   // Control FSM: IDLE -> LOOKUP -> ALLOC -> WRITE -> IDLE
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= ST_IDLE;
         pkt_ready     <= 1'b0;
         note_lut_addr <= 8'd0;
         alloc_idx     <= '0;
         alloc_inc     <= '0;
         steal_ptr     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               pkt_ready <= 1'b1;
               if (is_on) begin
                  state         <= ST_LOOKUP;
                  pkt_ready     <= 1'b0;
                  note_lut_addr <= MIDI_DAT_0;
               end
            end
            ST_LOOKUP: begin
               state <= ST_ALLOC;
            end
            ST_ALLOC: begin
               // Table data is valid here, one cycle after the LOOKUP address.
               alloc_inc <= note_lut_data;
               alloc_idx <= pick;
               if (pick_steal) begin
                  steal_ptr <= steal_ptr + VC_W'(1);
               end
               state <= ST_WRITE;
            end
            ST_WRITE: begin
               state     <= ST_IDLE;
               pkt_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               pkt_ready <= 1'b0;
            end
         endcase
      end
   end

   // The sine address follows the current slot's phase; it is stable for the
   // whole ISSUE cycle because phases only change on CAPTURE or WRITE edges.
   assign sin_addr      = phases[slot][PHASE_W-1 -: ADDR_W];
   assign voices_active = active;

   // TDM sequencer and per-voice state
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         slot             <= '0;
         seq_cap          <= 1'b0;
         TDM_VOICE_DATA   <= '0;
         TDM_CHANNEL      <= '0;
         TDM_CHAN_ENABLED <= 1'b0;
         TDM_VALID        <= 1'b0;
         active           <= '0;
         notes            <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            incs[v]   <= '0;
            phases[v] <= '0;
         end
      end else begin
         TDM_VALID <= 1'b0;
         seq_cap   <= ~seq_cap;
         if (seq_cap) begin
            // Reads the pre-update active flag, so a coincident note-off
            // still emits this slot's sample.
            slot             <= slot + VC_W'(1);
            TDM_VALID        <= 1'b1;
            TDM_CHANNEL      <= slot;
            TDM_CHAN_ENABLED <= active[slot];
            TDM_VOICE_DATA   <= active[slot] ? sin_data : '0;
         end
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (write_en && (alloc_idx == VC_W'(v))) begin
               // A fresh note restarts at phase 0 even if CAPTURE hits now.
               notes[v]  <= note_lut_addr;
               incs[v]   <= alloc_inc;
               active[v] <= 1'b1;
               phases[v] <= '0;
            end else begin
               if (seq_cap && (slot == VC_W'(v)) && active[v]) begin
                  phases[v] <= phases[v] + PHASE_W'(incs[v]);
               end
               if (is_off && (notes[v] == MIDI_DAT_0)) begin
                  active[v] <= 1'b0;
               end
            end
         end
      end
   end

endmodule
